imm_ext_unit: RTL and testbench
===============================

// Module: imm_ext_unit
// PURPOSE
//  Parametrised, registered immediate-extension stage for the multicycle RISC datapath.
//  Produces a DATA_W immediate from an IMM_W instruction field in one of three modes:
//  zero-extend, sign-extend, or sign-extend then shift left.
//  Adds a prefix register so a LOAD_PFX instruction can supply the upper bits of the
//  next immediate, which allows full-width constants.
//  Sits between instruction decode and the ALU-B/branch-offset muxes, using a valid/ready handshake.
// PARAMETERS
//  DATA_W   16  output immediate width
//  IMM_W     8  instruction immediate field width; must satisfy IMM_W < DATA_W
//  SHIFT     1  left-shift amount applied in SIGN_SHL mode (0..DATA_W-1)
//  PFX_TTL   3  idle cycles after which an armed prefix expires; 0 = never expires
//  PFX_W is derived: PFX_W = DATA_W-IMM_W. It must satisfy PFX_W <= IMM_W.
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  in_valid     in   1        request present
//  in_ready     out  1        unit can accept a request this cycle
//  imm_in       in   IMM_W    raw immediate field
//  mode         in   2        0 ZERO, 1 SIGN, 2 SIGN_SHL, 3 LOAD_PFX
//  flush        in   1        discard armed prefix and pending output (branch/exception)
//  out_valid    out  1        imm_out holds a result
//  out_ready    in   1        consumer takes the result this cycle
//  imm_out      out  DATA_W   extended immediate
//  pfx_used     out  1        imm_out was formed from the prefix
// BEHAVIOUR
//  - Reset (async, rst_n=0) clears all state:
//    - out_valid=0, imm_out=0, pfx_used=0.
//    - The prefix is disarmed, pfx_reg=0 and the TTL counter is 0.
//  - in_ready = !out_valid || out_ready. This is a one-entry pipeline register that supports full throughput.
//  - Accept = in_valid && in_ready && !flush. The result is registered, so out_valid rises the cycle after accept.
//  - ZERO: {0, imm_in}. SIGN: {sign(imm_in[IMM_W-1]), imm_in}.
//  - SIGN_SHL: the SIGN result << SHIFT, truncated to DATA_W, with zero fill at the bottom.
//  - LOAD_PFX:
//    - pfx_reg <= imm_in[PFX_W-1:0] and the prefix is armed; the TTL counter is cleared.
//    - No output is produced: out_valid falls if out_ready consumed the previous result.
//    - LOAD_PFX while already armed overwrites pfx_reg and restarts the TTL.
//  - A non-LOAD_PFX accept while the prefix is armed:
//    - imm_out = {pfx_reg, imm_in}, ignoring mode; pfx_used=1.
//    - The prefix is disarmed in the same edge.
//  - The output register holds its contents while out_valid && !out_ready. imm_out and pfx_used must not change while stalled.
//  - TTL: while armed and no accept occurs, the counter increments each cycle.
//    - When it reaches PFX_TTL, the prefix disarms.
//    - A request accepted in that same cycle still consumes the prefix (consume wins over expiry).
//  - flush:
//    - Takes priority over everything.
//    - Next edge: out_valid=0, pfx_used=0, prefix disarmed, TTL=0.
//    - Any request presented in the flush cycle is dropped.
//  - Reset mid-stall or mid-prefix returns to the reset state; no partial result survives.
//  - Elaboration check: an error is raised if IMM_W >= DATA_W, PFX_W > IMM_W, or SHIFT >= DATA_W.
// STRUCTURE
//  - Package imm_ext_pkg holds:
//    - localparams MODE_ZERO=2'd0, MODE_SIGN=2'd1, MODE_SIGN_SHL=2'd2, MODE_LOAD_PFX=2'd3;
//    - the mode width constant MODE_W=2.
//  - Sub-module imm_ext_core (combinational, parameters DATA_W/IMM_W/SHIFT) handles the ZERO/SIGN/SIGN_SHL datapath.
//  - The top level holds the prefix register, TTL counter, handshake and output register.
// TESTING (DATA_W=16, IMM_W=8, SHIFT=1, PFX_TTL=3, out_ready=1 unless stated)
//  1. ZERO 0xAA -> 0x00AA. SIGN 0xAA -> 0xFFAA. SIGN_SHL 0xAA -> 0xFF54.
//     SIGN 0x7F -> 0x007F. Each appears 1 cycle after accept, with pfx_used=0.
//  2. LOAD_PFX 0x12, then SIGN 0xAA -> 0x12AA with pfx_used=1. The following SIGN 0xAA -> 0xFFAA with pfx_used=0.
//  3. LOAD_PFX 0x12, idle 3 cycles, then ZERO 0x05 -> 0x0005 with pfx_used=0 (expired).
//     Repeat with the request on idle cycle 3 -> 0x1205.
//  4. Backpressure: result 0x00AA is held with out_ready=0 for 4 cycles, so in_ready=0 and imm_out is stable.
//     Then out_ready=1 while a new SIGN 0x80 is presented -> 0xFF80 on the next cycle, with no gap.
//  5. LOAD_PFX 0x34, then flush, then SIGN 0x01 -> 0x0001.
//     Flush asserted together with in_valid -> the request is dropped and out_valid=0.
//  6. Assert rst_n=0 asynchronously while stalled with the prefix armed:
//     out_valid, imm_out and pfx_used go to 0 immediately. The next SIGN 0xFF -> 0xFFFF.

Source files
------------

// File: rtl/imm_ext_pkg.sv
// Shared mode encodings for the immediate-extension stage.
// Imported by the extension datapath core and by the registered top level.
package imm_ext_pkg;

  localparam int MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_ZERO     = 2'd0;
  localparam logic [MODE_W-1:0] MODE_SIGN     = 2'd1;
  localparam logic [MODE_W-1:0] MODE_SIGN_SHL = 2'd2;
  localparam logic [MODE_W-1:0] MODE_LOAD_PFX = 2'd3;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational ZERO / SIGN / SIGN_SHL extension of an IMM_W field to DATA_W.
// LOAD_PFX produces no result here; the top level handles the prefix path.
module imm_ext_core
  import imm_ext_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int SHIFT  = 1
) (
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [MODE_W-1:0] mode,
  output logic [DATA_W-1:0] imm_ext
);

  localparam int PFX_W = DATA_W - IMM_W;

  logic signed [DATA_W-1:0] sext_p0;
  logic        [DATA_W-1:0] zext_p0;

  // Arithmetic left shift of the sign-extended value, truncated to DATA_W.
  function automatic logic [DATA_W-1:0] shl_trunc(input logic signed [DATA_W-1:0] v);
    logic signed [DATA_W-1:0] s;
    s = v <<< SHIFT;
    return unsigned'(s);
  endfunction

  assign zext_p0 = {{PFX_W{1'b0}}, imm_in};
  assign sext_p0 = signed'({{PFX_W{imm_in[IMM_W-1]}}, imm_in});

  always_comb begin
    imm_ext = zext_p0;
    case (mode)
      MODE_ZERO:     imm_ext = zext_p0;
      MODE_SIGN:     imm_ext = unsigned'(sext_p0);
      MODE_SIGN_SHL: imm_ext = shl_trunc(sext_p0);
      default:       imm_ext = zext_p0;
    endcase
  end

endmodule

// File: rtl/imm_ext_unit.sv
// Registered immediate-extension stage with a LOAD_PFX prefix register and expiry timer.
// One-entry output register with valid/ready handshake; flush drops prefix and pending result.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int IMM_W   = 8,
  parameter int SHIFT   = 1,
  parameter int PFX_TTL = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  imm_in,
  input  logic [MODE_W-1:0] mode,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] imm_out,
  output logic              pfx_used
);

  localparam int PFX_W = DATA_W - IMM_W;
  localparam int TTL_W = (PFX_TTL > 0) ? $clog2(PFX_TTL + 1) : 1;
  localparam logic [TTL_W-1:0] TTL_LAST = (PFX_TTL > 0) ? TTL_W'(PFX_TTL - 1) : '0;

  if (IMM_W >= DATA_W) begin : g_bad_imm_w
    $error("imm_ext_unit: IMM_W must be smaller than DATA_W");
  end
  if (PFX_W > IMM_W) begin : g_bad_pfx_w
    $error("imm_ext_unit: DATA_W-IMM_W must not exceed IMM_W");
  end
  if (SHIFT >= DATA_W) begin : g_bad_shift
    $error("imm_ext_unit: SHIFT must be smaller than DATA_W");
  end

  logic              accept_p0;
  logic              is_pfx_p0;
  logic [DATA_W-1:0] core_imm_p0;
  logic [DATA_W-1:0] next_imm_p0;

  logic              pfx_armed;
  logic [PFX_W-1:0]  pfx_reg;
  logic [TTL_W-1:0]  ttl_cnt;

  logic              vld_p1;
  logic [DATA_W-1:0] imm_p1;
  logic              pfx_used_p1;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W),
    .SHIFT  (SHIFT)
  ) u_core (
    .imm_in  (imm_in),
    .mode    (mode),
    .imm_ext (core_imm_p0)
  );

  // ---- stage p0: handshake and result selection ----
  assign in_ready    = !vld_p1 || out_ready;
  assign accept_p0   = in_valid && in_ready && !flush;
  assign is_pfx_p0   = (mode == MODE_LOAD_PFX);
  // An armed prefix overrides the mode and supplies the upper bits verbatim.
  assign next_imm_p0 = pfx_armed ? {pfx_reg, imm_in} : core_imm_p0;

  // ---- stage p1: output register, prefix state and expiry timer ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1      <= 1'b0;
      imm_p1      <= '0;
      pfx_used_p1 <= 1'b0;
      pfx_armed   <= 1'b0;
      pfx_reg     <= '0;
      ttl_cnt     <= '0;
    end else if (flush) begin
      vld_p1      <= 1'b0;
      pfx_used_p1 <= 1'b0;
      pfx_armed   <= 1'b0;
      ttl_cnt     <= '0;
    end else if (accept_p0) begin
      ttl_cnt <= '0;
      if (is_pfx_p0) begin
        pfx_reg   <= imm_in[PFX_W-1:0];
        pfx_armed <= 1'b1;
        vld_p1    <= 1'b0;
      end else begin
        vld_p1      <= 1'b1;
        imm_p1      <= next_imm_p0;
        pfx_used_p1 <= pfx_armed;
        pfx_armed   <= 1'b0;
      end
    end else begin
      if (out_ready) begin
        vld_p1 <= 1'b0;
      end
      // Accept is handled above, so a request landing on the expiry cycle still wins.
      if (pfx_armed && (PFX_TTL != 0)) begin
        if (ttl_cnt == TTL_LAST) begin
          pfx_armed <= 1'b0;
          ttl_cnt   <= '0;
        end else begin
          ttl_cnt <= ttl_cnt + TTL_W'(1);
        end
      end
    end
  end

  assign out_valid = vld_p1;
  assign imm_out   = imm_p1;
  assign pfx_used  = pfx_used_p1;

endmodule

// File: tb/tb_imm_ext_unit.sv
// Directed bench for imm_ext_unit: table of single-cycle vectors plus hand-written
// sequences for prefix expiry, backpressure, flush and asynchronous reset.
module tb_imm_ext_unit;
  import imm_ext_pkg::*;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  imm_in;
  logic [MODE_W-1:0] mode;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] imm_out;
  logic              pfx_used;

  int checks = 0;
  int errors = 0;

  imm_ext_unit #(
    .DATA_W  (DATA_W),
    .IMM_W   (IMM_W),
    .SHIFT   (1),
    .PFX_TTL (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imm_in    (imm_in),
    .mode      (mode),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .imm_out   (imm_out),
    .pfx_used  (pfx_used)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [MODE_W-1:0] mode;
    logic [IMM_W-1:0]  imm;
    logic              exp_vld;
    logic [DATA_W-1:0] exp_imm;
    logic              exp_pfx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [MODE_W-1:0] m, input logic [IMM_W-1:0] d);
    in_valid = v;
    mode     = m;
    imm_in   = d;
  endtask

  task automatic chk_out(input string name, input logic v, input logic [DATA_W-1:0] d,
                         input logic p);
    chk({name, "_vld"}, 32'(out_valid), 32'(v));
    if (v) begin
      chk({name, "_imm"}, 32'(imm_out), 32'(d));
      chk({name, "_pfx"}, 32'(pfx_used), 32'(p));
    end
  endtask

  initial begin
    vecs.push_back('{MODE_ZERO,     8'hAA, 1'b1, 16'h00AA, 1'b0});
    vecs.push_back('{MODE_SIGN,     8'hAA, 1'b1, 16'hFFAA, 1'b0});
    vecs.push_back('{MODE_SIGN_SHL, 8'hAA, 1'b1, 16'hFF54, 1'b0});
    vecs.push_back('{MODE_SIGN,     8'h7F, 1'b1, 16'h007F, 1'b0});
    vecs.push_back('{MODE_SIGN_SHL, 8'h7F, 1'b1, 16'h00FE, 1'b0});
    vecs.push_back('{MODE_ZERO,     8'h80, 1'b1, 16'h0080, 1'b0});
    vecs.push_back('{MODE_SIGN_SHL, 8'h80, 1'b1, 16'hFF00, 1'b0});
    vecs.push_back('{MODE_LOAD_PFX, 8'h12, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{MODE_SIGN,     8'hAA, 1'b1, 16'h12AA, 1'b1});
    vecs.push_back('{MODE_SIGN,     8'hAA, 1'b1, 16'hFFAA, 1'b0});
    vecs.push_back('{MODE_LOAD_PFX, 8'h34, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{MODE_LOAD_PFX, 8'h56, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{MODE_ZERO,     8'h01, 1'b1, 16'h5601, 1'b1});
    vecs.push_back('{MODE_LOAD_PFX, 8'h9A, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{MODE_SIGN_SHL, 8'hFF, 1'b1, 16'h9AFF, 1'b1});

    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, MODE_ZERO, 8'h00);
    #12;
    chk("rst_vld", 32'(out_valid), 32'd0);
    chk("rst_imm", 32'(imm_out), 32'd0);
    chk("rst_pfx", 32'(pfx_used), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    #5 rst_n = 1'b1;
    tick();

    // Table vectors, back to back at full throughput.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].imm);
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].exp_vld, vecs[i].exp_imm, vecs[i].exp_pfx);
    end
    drive(1'b0, MODE_ZERO, 8'h00);
    tick();
    chk("idle_vld", 32'(out_valid), 32'd0);

    // Prefix expiry: three idle cycles disarm it.
    drive(1'b1, MODE_LOAD_PFX, 8'h12);
    tick();
    drive(1'b0, MODE_ZERO, 8'h00);
    repeat (3) tick();
    drive(1'b1, MODE_ZERO, 8'h05);
    tick();
    chk_out("ttl_expired", 1'b1, 16'h0005, 1'b0);
    drive(1'b0, MODE_ZERO, 8'h00);
    tick();

    // Request on idle cycle 3 still consumes the prefix.
    drive(1'b1, MODE_LOAD_PFX, 8'h12);
    tick();
    drive(1'b0, MODE_ZERO, 8'h00);
    repeat (2) tick();
    drive(1'b1, MODE_ZERO, 8'h05);
    tick();
    chk_out("ttl_last_cycle", 1'b1, 16'h1205, 1'b1);
    drive(1'b0, MODE_ZERO, 8'h00);
    tick();

    // Backpressure: held result, blocked request, then gapless handoff.
    drive(1'b1, MODE_ZERO, 8'hAA);
    tick();
    chk_out("bp_first", 1'b1, 16'h00AA, 1'b0);
    out_ready = 1'b0;
    drive(1'b1, MODE_SIGN, 8'h01);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out($sformatf("bp_hold%0d", i), 1'b1, 16'h00AA, 1'b0);
      chk($sformatf("bp_in_ready%0d", i), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    drive(1'b1, MODE_SIGN, 8'h80);
    #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    tick();
    chk_out("bp_next", 1'b1, 16'hFF80, 1'b0);
    drive(1'b0, MODE_ZERO, 8'h00);
    tick();

    // Flush discards an armed prefix.
    drive(1'b1, MODE_LOAD_PFX, 8'h34);
    tick();
    drive(1'b0, MODE_ZERO, 8'h00);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b1, MODE_SIGN, 8'h01);
    tick();
    chk_out("flush_pfx", 1'b1, 16'h0001, 1'b0);

    // Flush together with a request drops the request and the pending result.
    flush = 1'b1;
    drive(1'b1, MODE_SIGN, 8'h7F);
    tick();
    chk("flush_drop_vld", 32'(out_valid), 32'd0);
    chk("flush_drop_pfx", 32'(pfx_used), 32'd0);
    flush = 1'b0;
    drive(1'b0, MODE_ZERO, 8'h00);
    tick();
    chk("flush_after_vld", 32'(out_valid), 32'd0);

    // Async reset while stalled clears outputs immediately.
    out_ready = 1'b0;
    drive(1'b1, MODE_ZERO, 8'hAA);
    tick();
    chk_out("rst_stall_pre", 1'b1, 16'h00AA, 1'b0);
    drive(1'b0, MODE_ZERO, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(out_valid), 32'd0);
    chk("arst_imm", 32'(imm_out), 32'd0);
    chk("arst_pfx", 32'(pfx_used), 32'd0);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();

    // Async reset with a prefix armed: the prefix must not survive.
    drive(1'b1, MODE_LOAD_PFX, 8'h12);
    tick();
    drive(1'b0, MODE_ZERO, 8'h00);
    #2 rst_n = 1'b0;
    #3 rst_n = 1'b1;
    tick();
    drive(1'b1, MODE_SIGN, 8'hFF);
    tick();
    chk_out("arst_pfx_next", 1'b1, 16'hFFFF, 1'b0);
    drive(1'b0, MODE_ZERO, 8'h00);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
